// File: rtl/dac_pkg.sv
// Shared constants for the DAC slew stager: channel count, code width
// and the IDLE/SLEW state encoding.
package dac_pkg;

    localparam int NUM_CH = 8;
    localparam int DAC_W  = 12;
    localparam int CH_W   = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SLEW = 1'b1;

    typedef logic [DAC_W-1:0] code_t;

endpackage

// File: rtl/dac_slew_stager_if.sv
// Write port bundle for the DAC slew stager.
// Ports: wr_valid/wr_ready handshake, wr_ch channel index, wr_data code.
interface dac_slew_stager_if;
    import dac_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [DAC_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_ch,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_ch,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/dac_slew_step.sv
// Combinational per-channel stepper: moves i_cur toward i_tgt by at most
// i_step (0 = jump straight to target), never wrapping past 0 or full scale.
// Ports: i_cur current code, i_tgt target, i_step max change, o_nxt result.
module dac_slew_step
    import dac_pkg::*;
(
    input  logic [DAC_W-1:0] i_cur,
    input  logic [DAC_W-1:0] i_tgt,
    input  logic [DAC_W-1:0] i_step,
    output logic [DAC_W-1:0] o_nxt
);

    logic [DAC_W:0] w_diff;
    logic [DAC_W:0] w_mag;
    logic           w_down;

    assign w_diff = {1'b0, i_tgt} - {1'b0, i_cur};
    assign w_down = w_diff[DAC_W];
    assign w_mag  = w_down ? ({1'b0, i_cur} - {1'b0, i_tgt}) : w_diff;

    // Step only when the gap exceeds i_step, so +/- step cannot overshoot
    always_comb begin
        o_nxt = i_tgt;
        if (i_step != '0 && w_mag > {1'b0, i_step}) begin
            if (w_down) o_nxt = i_cur - i_step;
            else        o_nxt = i_cur + i_step;
        end
    end

endmodule

// File: rtl/dac_slew_stager.sv
// Eight-channel DAC code stager: shadow writes, triggered commit to targets,
// optional slew-rate-limited ramp of outputs toward targets.
// Ports: clk, rst (sync, active-high), wr (write bundle), trigger,
// slew_step, slew_period, dac1..dac8 codes, busy (in SLEW), done pulse.
module dac_slew_stager
    import dac_pkg::*;
#(
    parameter logic [DAC_W-1:0] RESET_CODE = 12'd0
) (
    input  logic                clk,
    input  logic                rst,
    dac_slew_stager_if.slave    wr,
    input  logic                trigger,
    input  logic [DAC_W-1:0]    slew_step,
    input  logic [31:0]         slew_period,
    output logic [DAC_W-1:0]    dac1,
    output logic [DAC_W-1:0]    dac2,
    output logic [DAC_W-1:0]    dac3,
    output logic [DAC_W-1:0]    dac4,
    output logic [DAC_W-1:0]    dac5,
    output logic [DAC_W-1:0]    dac6,
    output logic [DAC_W-1:0]    dac7,
    output logic [DAC_W-1:0]    dac8,
    output logic                busy,
    output logic                done
);

    logic [DAC_W-1:0] r_shadow [NUM_CH];
    logic [DAC_W-1:0] r_tgt    [NUM_CH];
    logic [DAC_W-1:0] r_out    [NUM_CH];
    logic [NUM_CH-1:0] r_dirty;
    logic [0:0]        r_state;
    logic [31:0]       r_cnt;
    logic              r_done;
    logic              r_wr_ready;

    logic [DAC_W-1:0]  w_tgt_nxt  [NUM_CH];
    logic [DAC_W-1:0]  w_step_out [NUM_CH];
    logic [NUM_CH-1:0] w_dirty_nxt;
    logic              w_wr;
    logic              w_commit_diff;
    logic              w_diff_nxt;
    logic              w_tick;

    assign w_wr   = wr.wr_valid && r_wr_ready;
    assign w_tick = (r_cnt >= slew_period);

    // Targets as they will be after this edge; a same-cycle write only
    // reaches the shadow, so the commit sees the pre-write shadow.
    always_comb begin
        w_commit_diff = 1'b0;
        w_diff_nxt    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_tgt_nxt[i] = r_tgt[i];
            if (trigger && r_dirty[i]) begin
                w_tgt_nxt[i] = r_shadow[i];
                if (r_shadow[i] != r_out[i]) w_commit_diff = 1'b1;
            end
            if (w_tgt_nxt[i] != r_out[i]) w_diff_nxt = 1'b1;
        end
    end

    always_comb begin
        w_dirty_nxt = trigger ? '0 : r_dirty;
        if (w_wr) w_dirty_nxt[wr.wr_ch] = 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_step
        dac_slew_step u_step (
            .i_cur  (r_out[g]),
            .i_tgt  (r_tgt[g]),
            .i_step (slew_step),
            .o_nxt  (w_step_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= RESET_CODE;
                r_tgt[i]    <= RESET_CODE;
                r_out[i]    <= RESET_CODE;
            end
            r_dirty    <= '0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_wr_ready <= 1'b0;
        end else begin
            r_wr_ready <= 1'b1;
            r_done     <= 1'b0;
            r_dirty    <= w_dirty_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_tgt[i] <= w_tgt_nxt[i];
            end
            if (w_wr) r_shadow[wr.wr_ch] <= wr.wr_data;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (trigger) begin
                        if (slew_step == '0) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                r_out[i] <= w_tgt_nxt[i];
                            end
                        end else if (w_commit_diff) begin
                            r_state <= ST_SLEW;
                        end
                    end
                end
                ST_SLEW: begin
                    if (!w_diff_nxt) begin
                        // Outputs already sit on targets: finish
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_tick) begin
                        // Step uses the targets held before this edge
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_out[i] <= w_step_out[i];
                        end
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr.wr_ready = r_wr_ready;
    assign busy        = (r_state == ST_SLEW);
    assign done        = r_done;

    assign dac1 = r_out[0];
    assign dac2 = r_out[1];
    assign dac3 = r_out[2];
    assign dac4 = r_out[3];
    assign dac5 = r_out[4];
    assign dac6 = r_out[5];
    assign dac7 = r_out[6];
    assign dac8 = r_out[7];

endmodule

// File: tb/tb_dac_slew_stager.sv
// Directed bench for dac_slew_stager: table of instant-commit writes
// plus hand-written slew, retrigger, clamp and reset sequences.
module tb_dac_slew_stager;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic [11:0] slew_step;
    logic [31:0] slew_period;
    logic [11:0] dac [8];
    logic        busy;
    logic        done;

    int total;
    int bad;
    int pulses;

    dac_slew_stager_if wr_if ();

    dac_slew_stager #(.RESET_CODE(12'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr_if),
        .trigger     (trigger),
        .slew_step   (slew_step),
        .slew_period (slew_period),
        .dac1        (dac[0]),
        .dac2        (dac[1]),
        .dac3        (dac[2]),
        .dac4        (dac[3]),
        .dac5        (dac[4]),
        .dac6        (dac[5]),
        .dac7        (dac[6]),
        .dac8        (dac[7]),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
        logic [11:0] exp;
    } vec_t;

    vec_t vt [5];
    logic [11:0] e31 [15];
    logic [11:0] e34 [19];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [11:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = ch;
        wr_if.wr_data  = d;
        cyc();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic trig();
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        trigger = 1'b0;
        slew_step = 12'd0;
        slew_period = 32'd0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_ch = 3'd0;
        wr_if.wr_data = 12'd0;

        vt[0] = '{3'd2, 12'h400, 12'h400};
        vt[1] = '{3'd0, 12'hFFF, 12'hFFF};
        vt[2] = '{3'd7, 12'h00A, 12'h00A};
        vt[3] = '{3'd5, 12'h123, 12'h123};
        vt[4] = '{3'd0, 12'h000, 12'h000};

        e31 = '{12'd0, 12'd0, 12'd0, 12'd5, 12'd5, 12'd5,
                12'd10, 12'd10, 12'd10, 12'd15, 12'd15, 12'd15,
                12'd16, 12'd16, 12'd16};

        e34 = '{12'h010, 12'h010, 12'h010, 12'h010,
                12'h110, 12'h110, 12'h110, 12'h110,
                12'h210, 12'h210, 12'h210, 12'h210,
                12'h110, 12'h110, 12'h110, 12'h110,
                12'h100, 12'h100, 12'h100};

        // reset state
        cyc(); cyc(); cyc();
        for (int i = 0; i < 8; i++) chk("rst_dac", dac[i], 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", wr_if.wr_ready, 0);
        rst = 1'b0;
        cyc();
        chk("ready_up", wr_if.wr_ready, 1);

        // instant commit with slew_step = 0
        for (int i = 0; i < 5; i++) begin
            wr(vt[i].ch, vt[i].data);
            trig();
            chk("tbl_dac", dac[vt[i].ch], vt[i].exp);
            chk("tbl_done", done, 0);
            chk("tbl_busy", busy, 0);
        end
        chk("tbl_keep_ch2", dac[2], 12'h400);

        // slew 0 -> 16, step 5, period 2
        slew_step = 12'd5;
        slew_period = 32'd2;
        wr(3'd0, 12'h010);
        trig();
        pulses = 0;
        for (int n = 1; n <= 15; n++) begin
            chk("s31_dac1", dac[0], e31[n-1]);
            chk("s31_done", done, (n == 14) ? 1 : 0);
            chk("s31_busy", busy, (n <= 13) ? 1 : 0);
            if (done) pulses++;
            cyc();
        end
        chk("s31_pulses", pulses, 1);
        chk("s31_dac8", dac[7], 12'h00A);

        // clamp at zero, no underflow
        slew_step = 12'h100;
        slew_period = 32'd0;
        wr(3'd7, 12'h000);
        trig();
        chk("s32_n1", dac[7], 12'h00A);
        chk("s32_busy", busy, 1);
        cyc();
        chk("s32_n2", dac[7], 12'h000);
        cyc();
        chk("s32_done", done, 1);
        chk("s32_idle", busy, 0);
        cyc();
        chk("s32_done_lo", done, 0);

        // write and trigger in the same cycle
        slew_step = 12'd0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch = 3'd1;
        wr_if.wr_data = 12'h200;
        trigger = 1'b1;
        cyc();
        wr_if.wr_valid = 1'b0;
        trigger = 1'b0;
        chk("s33_old", dac[1], 12'h000);
        trig();
        chk("s33_new", dac[1], 12'h200);

        // trigger with nothing dirty
        slew_step = 12'd5;
        trig();
        chk("s24_busy", busy, 0);
        chk("s24_done", done, 0);
        cyc();
        chk("s24_done2", done, 0);

        // retrigger mid-slew, direction reverses, counter kept
        slew_step = 12'h100;
        slew_period = 32'd3;
        wr(3'd0, 12'h800);
        trig();
        pulses = 0;
        for (int n = 1; n <= 19; n++) begin
            chk("s34_dac1", dac[0], e34[n-1]);
            chk("s34_done", done, (n == 18) ? 1 : 0);
            chk("s34_busy", busy, (n <= 17) ? 1 : 0);
            if (done) pulses++;
            if (n == 9) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_ch = 3'd0;
                wr_if.wr_data = 12'h100;
            end
            if (n == 10) begin
                wr_if.wr_valid = 1'b0;
                trigger = 1'b1;
            end
            if (n == 11) trigger = 1'b0;
            cyc();
        end
        chk("s34_pulses", pulses, 1);

        // reset in the middle of a slew
        slew_step = 12'h010;
        slew_period = 32'd0;
        wr(3'd0, 12'h800);
        trig();
        chk("s35_n1", dac[0], 12'h100);
        cyc();
        chk("s35_n2", dac[0], 12'h110);
        cyc();
        chk("s35_n3", dac[0], 12'h120);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) chk("s35_dac", dac[i], 0);
        chk("s35_busy", busy, 0);
        chk("s35_done", done, 0);
        chk("s35_ready", wr_if.wr_ready, 0);
        cyc();
        chk("s35_ready_up", wr_if.wr_ready, 1);
        chk("s35_hold", dac[0], 0);
        chk("s35_busy2", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_slew_stager.md
DAC_SLEW_STAGER -- requirements
Module: dac_slew_stager

Interface
REQ-001 SHALL have parameter: RESET_CODE, 12'd0, code driven on all outputs and held in all shadow/target registers after reset.
REQ-002 SHALL have ports: clk  in  1  system clock, 200 MHz.
REQ-003 SHALL have ports: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports: wr_valid  in  1  write request.
REQ-005 SHALL have ports: wr_ready  out  1  write accept; high whenever rst is low.
REQ-006 SHALL have ports: wr_ch  in  3  channel index 0..7 (channel 0 = dac1).
REQ-007 SHALL have ports: wr_data  in  12  new code for wr_ch.
REQ-008 SHALL have ports: trigger  in  1  single-cycle pulse committing dirty shadows to targets.
REQ-009 SHALL have ports: slew_step  in  12  max code change per tick; 0 = no slew limiting.
REQ-010 SHALL have ports: slew_period  in  32  tick interval minus one, in clk cycles.
REQ-011 SHALL have ports: dac1..dac8  out  12 each  codes feeding the DAC128S085 driver.
REQ-012 SHALL have ports: busy  out  1  high while in SLEW.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse on SLEW->IDLE.

Function
REQ-014 SHALL write wr_data into shadow[wr_ch] and set dirty[wr_ch] on every cycle where wr_valid and wr_ready are both high.
REQ-015 SHALL, on trigger high, copy every dirty shadow into its target, then clear those dirty bits at the same edge.
REQ-016 SHALL, on trigger high together with a write, commit the pre-write shadow; the new write SHALL land in the shadow, and its dirty bit SHALL remain set.
REQ-017 SHALL implement states IDLE and SLEW; IDLE SHALL be the reset state.
REQ-018 SHALL, when slew_step==0 and a trigger arrives at cycle N, load the committed targets directly into the outputs, visible in cycle N+1, and stay in IDLE.
REQ-019 SHALL, when slew_step!=0 and a trigger commits at least one target differing from its output, enter SLEW at cycle N+1 with the tick counter at 0.
REQ-020 SHALL increment the tick counter each SLEW cycle; at counter==slew_period, SHALL apply one step to all channels and clear the counter; the first step SHALL be visible at cycle N+2+slew_period.
REQ-021 SHALL compute each channel step as: if |target-out| <= slew_step then out=target, else out = out +/- slew_step toward target; unsigned 12-bit arithmetic using a 13-bit difference, with no wrap past 0 or 4095.
REQ-022 SHALL, in SLEW, accept a trigger: targets update at that edge, the step applied at the same edge SHALL use the old targets, and the counter SHALL NOT reset.
REQ-023 SHALL transition SLEW->IDLE at the edge after all outputs equal their targets, and SHALL pulse done for exactly that first IDLE cycle.
REQ-024 SHALL, on a trigger with no dirty channels or with all targets equal to the outputs, remain in IDLE and SHALL NOT pulse done.
REQ-025 SHALL sample slew_step and slew_period live each cycle; a change of either mid-SLEW SHALL take effect from the next cycle.

Reset
REQ-026 SHALL, while rst is high at a clk edge, set outputs/shadows/targets=RESET_CODE, dirty=0, state=IDLE, counter=0, busy=0, done=0, wr_ready=0.
REQ-027 SHALL abort an in-progress SLEW on rst, with no partial step applied.

Structure
REQ-028 SHALL take NUM_CH=8, DAC_W=12 and the IDLE/SLEW state encoding from shared package dac_pkg.
REQ-029 SHALL instantiate the per-channel stepper (compare plus clamp/step, combinational) as sub-module dac_slew_step, eight instances.

Verification
REQ-030 SHALL verify: write ch2=0x400, step=0, trigger at N -> dac3=0x400 at N+1, done stays 0.
REQ-031 SHALL verify: dac1=0, write ch0=0x010, step=5, period=2, trigger -> dac1 reads 5, 10, 15, 16 at 3-cycle spacing, first at N+4; done pulses once after the final step.
REQ-032 SHALL verify: dac8=0x00A, target 0x000, step=0x100 -> dac8=0 on the first tick, no underflow to 0xF0A.
REQ-033 SHALL verify: write ch1=0x200 and trigger in the same cycle -> target keeps its old value; a second trigger commits 0x200.
REQ-034 SHALL verify: mid-SLEW ch0 toward 0x800, retrigger with 0x100 -> direction reverses at the next tick, counter is not restarted, and done pulses once.
REQ-035 SHALL verify: rst asserted mid-SLEW -> all outputs=RESET_CODE, busy=0, and wr_ready=0 on the next cycle.
